bbc_mem_arbiter: RTL and testbench

Time-division memory arbiter for the BBC micro core. It shares one synchronous single-port memory between the 6502 and the CRTC/video fetch path by slotting one video access and one CPU access into every 2 MHz cycle. It also decodes CPU addresses into RAM, OS ROM and paged ROM, owns the ROMSEL bank latch, and translates CRTC framestore/row addresses with screen wrap-around. It sits between the processor, MC6845, VideoULA and the memory array, all clocked from clk16MHz.

---
 rtl/bbc_mem_pkg.sv | 37 +++
 rtl/bbc_video_addr.sv | 28 ++
 rtl/bbc_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bbc_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbc_mem_pkg.sv
// Shared constants and types for the BBC memory arbiter: select encodings,
// capture owner tags, slot numbers, CPU decode ranges and screen wrap offsets.
package bbc_mem_pkg;

    // mem_sel encodings
    localparam logic [1:0] SelRam      = 2'b00;
    localparam logic [1:0] SelOsRom    = 2'b01;
    localparam logic [1:0] SelPagedRom = 2'b10;

    // Owner of a read issued in the previous cycle
    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagVid  = 2'd1,
        TagCpu  = 2'd2
    } owner_tag_e;

    // Slot in which a ROMSEL write is committed
    localparam logic [2:0] SlotRomsel = 3'd7;

    // CPU decode: I/O pages &FC..&FE, ROMSEL at &FE30-&FE3F
    localparam logic [7:0]  IoPageFirst = 8'hFC;
    localparam logic [7:0]  IoPageLast  = 8'hFE;
    localparam logic [11:0] RomselHi    = 12'hFE3;

    // Amount subtracted from a framestore address that ran past &8000
    function automatic logic [14:0] wrap_offset(input logic [1:0] screen_size);
        logic [14:0] off;
        unique case (screen_size)
            2'b00:   off = 15'h5000;
            2'b01:   off = 15'h4000;
            2'b10:   off = 15'h2800;
            default: off = 15'h2000;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/bbc_video_addr.sv
// Translates CRTC framestore/row addresses into a 15-bit RAM address,
// folding addresses that overflow the top of RAM back into the screen area.
module bbc_video_addr
    import bbc_mem_pkg::*;
(
    input  logic [13:0] i_framestore,
    input  logic [2:0]  i_row,
    input  logic [1:0]  i_screen_size,
    output logic [14:0] o_addr
);

    logic [14:0] w_base;
    logic        w_unused_ma13;

    // MA13 plays no part in the RAM address
    assign w_unused_ma13 = i_framestore[13];

    assign w_base = {i_framestore[11:0], i_row};

    // Wrap subtraction is modulo 2^15; the borrow is discarded
    always_comb begin
        o_addr = w_base;
        if (i_framestore[12]) begin
            o_addr = w_base - wrap_offset(i_screen_size);
        end
    end

endmodule

// File: rtl/bbc_mem_arbiter.sv
// Time-division arbiter sharing one synchronous memory between video and CPU,
// with CPU address decode, the ROMSEL bank latch and tagged read capture.
module bbc_mem_arbiter
    import bbc_mem_pkg::*;
#(
    parameter int unsigned SLOT_VID = 1,
    parameter int unsigned SLOT_CPU = 5
) (
    input  logic        clk16MHz,
    input  logic        RESET,
    input  logic        clk2MHz,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_io,
    input  logic [13:0] vid_framestore,
    input  logic [2:0]  vid_row,
    input  logic [1:0]  screen_size,
    output logic [7:0]  vid_rdata,
    output logic        vid_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_sel,
    output logic [3:0]  mem_bank,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [3:0]  rom_bank
);

    localparam logic [2:0] SlotVid = 3'(SLOT_VID);
    localparam logic [2:0] SlotCpu = 3'(SLOT_CPU);

    logic [2:0]  r_slot;
    logic        r_clk2;
    owner_tag_e  r_tag;
    logic [7:0]  r_cpu_rdata;
    logic        r_cpu_rvalid;
    logic [7:0]  r_vid_rdata;
    logic        r_vid_rvalid;
    logic [3:0]  r_rom_bank;

    logic        w_clk2_rise;
    logic        w_dec_ram;
    logic        w_dec_paged;
    logic        w_dec_io;
    logic        w_dec_os;
    logic        w_romsel_wr;
    logic [14:0] w_vid_addr;
    owner_tag_e  w_issue_tag;

    assign w_clk2_rise = clk2MHz & ~r_clk2;

    assign w_dec_ram   = ~cpu_addr[15];
    assign w_dec_paged = (cpu_addr[15:14] == 2'b10);
    assign w_dec_io    = (cpu_addr[15:8] >= IoPageFirst) && (cpu_addr[15:8] <= IoPageLast);
    assign w_dec_os    = (cpu_addr[15:14] == 2'b11) && !w_dec_io;
    assign w_romsel_wr = (cpu_addr[15:4] == RomselHi) && !cpu_rnw;

    assign cpu_io     = w_dec_io;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign vid_rdata  = r_vid_rdata;
    assign vid_rvalid = r_vid_rvalid;
    assign rom_bank   = r_rom_bank;

    bbc_video_addr u_video_addr (
        .i_framestore  (vid_framestore),
        .i_row         (vid_row),
        .i_screen_size (screen_size),
        .o_addr        (w_vid_addr)
    );

    // Slot counter: free-runs, realigned to 0 after each sampled clk2MHz rise
    always_ff @(posedge clk16MHz or posedge RESET) begin
        if (RESET) begin
            r_slot <= 3'd0;
            r_clk2 <= 1'b0;
        end else begin
            r_clk2 <= clk2MHz;
            r_slot <= w_clk2_rise ? 3'd0 : r_slot + 3'd1;
        end
    end

    // Memory request for the current slot and the owner tag of any read issued
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = SelRam;
        mem_bank    = 4'd0;
        mem_addr    = 15'd0;
        mem_wdata   = 8'd0;
        w_issue_tag = TagNone;
        if (r_slot == SlotVid) begin
            mem_req     = 1'b1;
            mem_addr    = w_vid_addr;
            w_issue_tag = TagVid;
        end else if (r_slot == SlotCpu) begin
            if (w_dec_ram) begin
                mem_req  = 1'b1;
                mem_addr = cpu_addr[14:0];
                if (cpu_rnw) begin
                    w_issue_tag = TagCpu;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = cpu_wdata;
                end
            end else if (w_dec_paged && cpu_rnw) begin
                mem_req     = 1'b1;
                mem_sel     = SelPagedRom;
                mem_bank    = r_rom_bank;
                mem_addr    = {1'b0, cpu_addr[13:0]};
                w_issue_tag = TagCpu;
            end else if (w_dec_os && cpu_rnw) begin
                mem_req     = 1'b1;
                mem_sel     = SelOsRom;
                mem_addr    = {1'b0, cpu_addr[13:0]};
                w_issue_tag = TagCpu;
            end
        end
    end

    // Delay the owner tag so it lines up with the returning read data
    always_ff @(posedge clk16MHz or posedge RESET) begin
        if (RESET) begin
            r_tag <= TagNone;
        end else begin
            r_tag <= w_issue_tag;
        end
    end

    // Capture keyed to the tag, so a resync cannot lose or duplicate a read
    always_ff @(posedge clk16MHz or posedge RESET) begin
        if (RESET) begin
            r_cpu_rdata  <= 8'h00;
            r_cpu_rvalid <= 1'b0;
            r_vid_rdata  <= 8'h00;
            r_vid_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            r_vid_rvalid <= 1'b0;
            unique case (r_tag)
                TagVid: begin
                    r_vid_rdata  <= mem_rdata;
                    r_vid_rvalid <= 1'b1;
                end
                TagCpu: begin
                    r_cpu_rdata  <= mem_rdata;
                    r_cpu_rvalid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ROMSEL latch, committed at the end of the ROMSEL slot
    always_ff @(posedge clk16MHz or posedge RESET) begin
        if (RESET) begin
            r_rom_bank <= 4'd0;
        end else if ((r_slot == SlotRomsel) && w_romsel_wr) begin
            r_rom_bank <= cpu_wdata[3:0];
        end
    end

endmodule

// File: tb/tb_bbc_mem_arbiter.sv
// Directed bench for bbc_mem_arbiter with a synchronous memory model.
module tb_bbc_mem_arbiter;

    logic        clk16MHz = 1'b0;
    logic        RESET;
    logic        clk2MHz;
    logic [15:0] cpu_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_io;
    logic [13:0] vid_framestore;
    logic [2:0]  vid_row;
    logic [1:0]  screen_size;
    logic [7:0]  vid_rdata;
    logic        vid_rvalid;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [3:0]  mem_bank;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [3:0]  rom_bank;

    logic [7:0]  ram [32768];
    logic        pl_en = 1'b0;
    logic [14:0] pl_addr = 15'd0;
    logic [7:0]  pl_data = 8'd0;

    int n_cmp = 0;
    int n_err = 0;
    int s = 0;
    int resync = 0;
    int n_pulse;

    always #5 clk16MHz = ~clk16MHz;

    bbc_mem_arbiter #(
        .SLOT_VID (1),
        .SLOT_CPU (5)
    ) dut (
        .clk16MHz       (clk16MHz),
        .RESET          (RESET),
        .clk2MHz        (clk2MHz),
        .cpu_addr       (cpu_addr),
        .cpu_rnw        (cpu_rnw),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_io         (cpu_io),
        .vid_framestore (vid_framestore),
        .vid_row        (vid_row),
        .screen_size    (screen_size),
        .vid_rdata      (vid_rdata),
        .vid_rvalid     (vid_rvalid),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_sel        (mem_sel),
        .mem_bank       (mem_bank),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .rom_bank       (rom_bank)
    );

    // Memory: RAM array, paged ROM returns {bank, addr[3:0]}, OS ROM returns E0^addr[7:0]
    always @(posedge clk16MHz) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_req) begin
            if (mem_we) begin
                if (mem_sel == 2'b00) ram[mem_addr] <= mem_wdata;
            end else begin
                case (mem_sel)
                    2'b00:   mem_rdata <= ram[mem_addr];
                    2'b01:   mem_rdata <= 8'hE0 ^ mem_addr[7:0];
                    2'b10:   mem_rdata <= {mem_bank, mem_addr[3:0]};
                    default: mem_rdata <= 8'hEE;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; s tracks the slot the DUT should be in afterwards
    task automatic cyc();
        @(posedge clk16MHz);
        if (resync != 0) begin
            s = 0;
            resync = 0;
        end else begin
            s = (s + 1) % 8;
        end
        @(negedge clk16MHz);
        pl_en = 1'b0;
    endtask

    task automatic goto_slot(input int target);
        do cyc(); while (s != target);
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        cyc();
    endtask

    task automatic cpu_set(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        cpu_addr  = a;
        cpu_rnw   = rnw;
        cpu_wdata = d;
    endtask

    initial begin
        RESET = 1'b1;
        clk2MHz = 1'b0;
        cpu_set(16'h1234, 1'b1, 8'h00);
        vid_framestore = 14'h1000;
        vid_row = 3'd5;
        screen_size = 2'b01;
        @(negedge clk16MHz);
        preload(15'h1234, 8'h5A);
        preload(15'h4005, 8'hC3);

        chk("rst_mem_req", mem_req, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_vid_rdata", vid_rdata, 8'h00);
        chk("rst_rvalids", {cpu_rvalid, vid_rvalid}, 0);
        chk("rst_rom_bank", rom_bank, 0);
        chk("rst_mem_fields", {mem_we, mem_sel, mem_bank, mem_addr, mem_wdata}, 0);

        // Period 1: video wrap (size 01) and CPU RAM read of &1234
        RESET = 1'b0;
        s = 0;
        chk("slot0_no_req", mem_req, 0);
        cyc();
        chk("vid_req", {mem_req, mem_we, mem_sel}, 4'b1000);
        chk("vid_wrap_01", mem_addr, 15'h4005);
        cyc();
        chk("vid_rvalid_not_early", vid_rvalid, 0);
        cyc();
        chk("vid_rvalid", vid_rvalid, 1);
        chk("vid_rdata", vid_rdata, 8'hC3);
        cyc();
        chk("vid_rvalid_one_cycle", vid_rvalid, 0);
        goto_slot(5);
        chk("cpu_rd_req", {mem_req, mem_we, mem_sel}, 4'b1000);
        chk("cpu_rd_addr", mem_addr, 15'h1234);
        goto_slot(7);
        chk("cpu_rvalid", cpu_rvalid, 1);
        chk("cpu_rdata", cpu_rdata, 8'h5A);
        goto_slot(0);
        chk("cpu_rvalid_one_cycle", cpu_rvalid, 0);
        chk("cpu_rdata_hold", cpu_rdata, 8'h5A);

        // Period 2: unwrapped video, RAM write &77 -> &0100
        vid_framestore = 14'h0ABC;
        vid_row = 3'd3;
        screen_size = 2'b00;
        cpu_set(16'h0100, 1'b0, 8'h77);
        goto_slot(1);
        chk("vid_nowrap", mem_addr, 15'h55E3);
        goto_slot(5);
        chk("cpu_wr_req_we", {mem_req, mem_we, mem_sel}, 4'b1100);
        chk("cpu_wr_addr", mem_addr, 15'h0100);
        chk("cpu_wr_data", mem_wdata, 8'h77);
        goto_slot(6);
        cpu_set(16'h0100, 1'b1, 8'h00);
        vid_framestore = 14'h1010;
        vid_row = 3'd7;
        screen_size = 2'b10;
        goto_slot(1);
        chk("vid_wrap_10", mem_addr, 15'h5887);
        goto_slot(5);
        chk("cpu_rdback_req", {mem_req, mem_we, mem_addr}, {2'b10, 15'h0100});
        goto_slot(7);
        chk("cpu_rdback", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h77});

        // ROMSEL write, then paged ROM read
        goto_slot(0);
        vid_framestore = 14'h1FFF;
        vid_row = 3'd7;
        screen_size = 2'b11;
        cpu_set(16'hFE30, 1'b0, 8'h03);
        goto_slot(1);
        chk("vid_wrap_11", mem_addr, 15'h5FFF);
        goto_slot(5);
        chk("romsel_no_req", mem_req, 0);
        chk("romsel_io", cpu_io, 1);
        goto_slot(7);
        chk("romsel_not_yet", rom_bank, 0);
        chk("io_no_rvalid", cpu_rvalid, 0);
        goto_slot(0);
        chk("romsel_latched", rom_bank, 3);
        cpu_set(16'h8000, 1'b1, 8'h00);
        goto_slot(5);
        chk("paged_req", {mem_req, mem_we, mem_sel, mem_bank}, {2'b10, 2'b10, 4'd3});
        chk("paged_addr", mem_addr, 15'h0000);
        goto_slot(7);
        chk("paged_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h30});

        // ROM write ignored, I/O read ignored, OS ROM read
        goto_slot(0);
        cpu_set(16'hC010, 1'b0, 8'h55);
        goto_slot(5);
        chk("rom_wr_no_req", mem_req, 0);
        chk("rom_wr_not_io", cpu_io, 0);
        goto_slot(0);
        cpu_set(16'hFE40, 1'b1, 8'h00);
        goto_slot(5);
        chk("io_rd_no_req", mem_req, 0);
        chk("io_rd_io", cpu_io, 1);
        goto_slot(7);
        chk("io_rd_no_rvalid", {cpu_rvalid, cpu_rdata}, {1'b0, 8'h30});
        goto_slot(0);
        cpu_set(16'hFFFC, 1'b1, 8'h00);
        goto_slot(5);
        chk("os_req", {mem_req, mem_we, mem_sel}, 4'b1001);
        chk("os_addr", mem_addr, 15'h3FFC);
        goto_slot(7);
        chk("os_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h1C});

        // Resync right after a CPU request in slot 5
        preload(15'h1234, 8'hA5);
        cpu_set(16'h1234, 1'b1, 8'h00);
        goto_slot(5);
        chk("resync_req", {mem_req, mem_addr}, {1'b1, 15'h1234});
        clk2MHz = 1'b1;
        resync = 1;
        cyc();
        chk("resync_slot0_no_req", mem_req, 0);
        chk("resync_not_early", cpu_rvalid, 0);
        clk2MHz = 1'b0;
        cpu_set(16'hFE40, 1'b1, 8'h00);
        n_pulse = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (cpu_rvalid) n_pulse++;
            if (s == 1) begin
                chk("resync_slot1_vid_req", mem_req, 1);
                chk("resync_capture", {cpu_rvalid, cpu_rdata}, {1'b1, 8'hA5});
            end
        end
        chk("resync_one_pulse", n_pulse, 1);

        // Reset pulsed during slot 5
        cpu_set(16'h1234, 1'b1, 8'h00);
        goto_slot(5);
        chk("pre_reset_req", mem_req, 1);
        RESET = 1'b1;
        #1;
        chk("reset_mid_req", {mem_req, mem_we, mem_sel, mem_addr}, 0);
        chk("reset_mid_regs", {rom_bank, cpu_rdata, vid_rdata}, 0);
        chk("reset_mid_valid", {cpu_rvalid, vid_rvalid, cpu_io}, 0);
        @(posedge clk16MHz);
        @(negedge clk16MHz);
        RESET = 1'b0;
        s = 0;
        chk("post_reset_slot0", {mem_req, cpu_rvalid}, 0);
        cyc();
        chk("post_reset_slot1_req", mem_req, 1);
        chk("post_reset_dropped", cpu_rvalid, 0);
        cyc();
        chk("post_reset_no_capture", {cpu_rvalid, cpu_rdata}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
